game_round_controller: RTL and testbench

- Round sequencer for the VGA torpedo game; sits between the input/collision logic and the sprite engines/RGB mixer.
- Spawns the target and launches the torpedo. Decides win or loss from collision and off-screen events.
- Runs the end-of-game timer, keeps a pseudo-random bit stream and a hit score.
- Outputs feed the mixer's `game_won`, `end_of_game_timer_running` and `random` inputs directly.

---
 rtl/game_round_controller.sv | 171 +++++++++++++++++
 tb/tb_game_round_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_controller.sv
// Round sequencer for the VGA torpedo game: spawns the target, launches the torpedo,
// decides win/loss, times the end-of-game display and provides a score and random bit.
module game_round_controller #(
  parameter int          END_TIMER_FRAMES = 60,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       launch_req,
  input  logic       collision,
  input  logic       target_out,
  input  logic       torpedo_out,
  output logic       target_spawn,
  output logic       torpedo_launch,
  output logic       target_move,
  output logic       torpedo_move,
  output logic       game_won,
  output logic       end_of_game_timer_running,
  output logic       random,
  output logic [7:0] score
);

  typedef enum logic [1:0] {
    SPAWN  = 2'd0,
    AIM    = 2'd1,
    FLIGHT = 2'd2,
    END    = 2'd3
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(END_TIMER_FRAMES - 1);
  localparam logic [7:0] SCORE_MAX  = 8'd255;

  // Fibonacci step; an all-zero register is steered back to the seed so it can never lock up
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    if (l == 16'h0000) begin
      lfsr_step = LFSR_SEED;
    end else begin
      lfsr_step = {l[14:0], fb};
    end
  endfunction

  function automatic logic in_play(input state_t s);
    in_play = (s == AIM) || (s == FLIGHT);
  endfunction

  state_t      state;
  state_t      next_state;
  logic [7:0]  end_timer;
  logic [15:0] lfsr;
  logic        win;
  logic        loss;
  logic        launch;

  // next-state and round-outcome decode
  always_comb begin
    next_state = state;
    win        = 1'b0;
    loss       = 1'b0;
    launch     = 1'b0;
    case (state)
      SPAWN: begin
        next_state = AIM;
      end
      AIM: begin
        if (target_out) begin
          next_state = END;
          loss       = 1'b1;
        end else if (launch_req) begin
          next_state = FLIGHT;
          launch     = 1'b1;
        end else begin
          next_state = AIM;
        end
      end
      FLIGHT: begin
        // a collision outranks any simultaneous off-screen event
        if (collision) begin
          next_state = END;
          win        = 1'b1;
        end else if (target_out || torpedo_out) begin
          next_state = END;
          loss       = 1'b1;
        end else begin
          next_state = FLIGHT;
        end
      end
      END: begin
        if (frame_tick && (end_timer == TIMER_LAST)) begin
          next_state = SPAWN;
        end else begin
          next_state = END;
        end
      end
      default: begin
        next_state = SPAWN;
      end
    endcase
  end

  // state register and end-of-game frame timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SPAWN;
      end_timer <= 8'd0;
    end else begin
      state <= next_state;
      if (state != END) begin
        end_timer <= 8'd0;
      end else if (frame_tick) begin
        end_timer <= end_timer + 8'd1;
      end else begin
        end_timer <= end_timer;
      end
    end
  end

  // pulse and move outputs; moves are gated by both states so they never show in SPAWN or END
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_spawn   <= 1'b0;
      torpedo_launch <= 1'b0;
      target_move    <= 1'b0;
      torpedo_move   <= 1'b0;
    end else begin
      target_spawn   <= (state == SPAWN);
      torpedo_launch <= launch;
      target_move    <= frame_tick && in_play(state) && in_play(next_state);
      torpedo_move   <= frame_tick && (state == FLIGHT) && (next_state == FLIGHT);
    end
  end

  // round result, end display flag and saturating score
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_won                  <= 1'b0;
      end_of_game_timer_running <= 1'b0;
      score                     <= 8'd0;
    end else begin
      end_of_game_timer_running <= (next_state == END);
      if (state == SPAWN) begin
        game_won <= 1'b0;
      end else if (win) begin
        game_won <= 1'b1;
      end else if (loss) begin
        game_won <= 1'b0;
      end else begin
        game_won <= game_won;
      end
      if (win && (score != SCORE_MAX)) begin
        score <= score + 8'd1;
      end else begin
        score <= score;
      end
    end
  end

  // free-running pseudo-random generator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr   <= LFSR_SEED;
      random <= LFSR_SEED[15];
    end else begin
      lfsr   <= lfsr_step(lfsr);
      random <= lfsr[15];
    end
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Scoreboard bench for game_round_controller: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT presents spawn/launch/end events.
module tb_game_round_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       launch_req = 1'b0;
  logic       collision = 1'b0;
  logic       target_out = 1'b0;
  logic       torpedo_out = 1'b0;
  logic       target_spawn;
  logic       torpedo_launch;
  logic       target_move;
  logic       torpedo_move;
  logic       game_won;
  logic       end_of_game_timer_running;
  logic       random;
  logic [7:0] score;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int FRAMES = 60;

  localparam logic [2:0] K_SPAWN  = 3'd1;
  localparam logic [2:0] K_LAUNCH = 3'd2;
  localparam logic [2:0] K_ENTER  = 3'd3;
  localparam logic [2:0] K_EXIT   = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic       won;
    logic [7:0] score;
    logic [7:0] ticks;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_score = 0;
  logic prev_eotr = 1'b0;
  int   tick_cnt = 0;

  game_round_controller #(.END_TIMER_FRAMES(FRAMES), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch_req(launch_req),
    .collision(collision), .target_out(target_out), .torpedo_out(torpedo_out),
    .target_spawn(target_spawn), .torpedo_launch(torpedo_launch),
    .target_move(target_move), .torpedo_move(torpedo_move), .game_won(game_won),
    .end_of_game_timer_running(end_of_game_timer_running), .random(random), .score(score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] k, input logic w, input int s, input int t);
    exp_t e;
    e.kind = k; e.won = w; e.score = 8'(s); e.ticks = 8'(t);
    return e;
  endfunction

  task automatic pop_check(input logic [2:0] kind);
    exp_t e;
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event actual=%0d required=none", kind);
    end else begin
      e = q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (kind == e.kind && (kind == K_SPAWN || kind == K_ENTER)) begin
        check("event_won", 32'(game_won), 32'(e.won));
        check("event_score", 32'(score), 32'(e.score));
      end
      if (kind == e.kind && kind == K_EXIT) check("end_ticks", 32'(tick_cnt), 32'(e.ticks));
    end
  endtask

  // monitor: pops expectations when the DUT shows an event
  always @(negedge clk) begin
    if (rst) begin
      prev_eotr = 1'b0;
      tick_cnt  = 0;
    end else begin
      if (target_spawn) pop_check(K_SPAWN);
      if (torpedo_launch) pop_check(K_LAUNCH);
      if (target_spawn || torpedo_launch)
        check("spawn_launch_overlap", 32'(target_spawn & torpedo_launch), 32'd0);
      if (end_of_game_timer_running && !prev_eotr) begin
        pop_check(K_ENTER);
        tick_cnt = 0;
      end
      if (end_of_game_timer_running) begin
        check("move_in_end", 32'({target_move, torpedo_move}), 32'd0);
        if (frame_tick) tick_cnt++;
      end
      if (!end_of_game_timer_running && prev_eotr) pop_check(K_EXIT);
      prev_eotr = end_of_game_timer_running;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_target_spawn", 32'(target_spawn), 32'd0);
    check("rst_torpedo_launch", 32'(torpedo_launch), 32'd0);
    check("rst_moves", 32'({target_move, torpedo_move}), 32'd0);
    check("rst_game_won", 32'(game_won), 32'd0);
    check("rst_eotr", 32'(end_of_game_timer_running), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_random", 32'(random), 32'(SEED[15]));
  endtask

  // release reset and follow the first 16 random bits against an independent LFSR model
  task automatic release_and_check_lfsr();
    logic [15:0] m;
    logic        want;
    m = SEED;
    q.push_back(mk(K_SPAWN, 1'b0, 0, 0));
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      want = m[15];
      step();
      check("random_seq", 32'(random), 32'(want));
      if (k == 1) check("first_spawn", 32'(target_spawn), 32'd1);
      if (k == 2) check("spawn_one_cycle", 32'(target_spawn), 32'd0);
      if (k == 3) check("score_after_3", 32'(score), 32'd0);
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end
  endtask

  task automatic do_launch();
    q.push_back(mk(K_LAUNCH, 1'b0, 0, 0));
    launch_req = 1'b1;
    step();
    launch_req = 1'b0;
  endtask

  task automatic finish_end();
    q.push_back(mk(K_EXIT, 1'b0, 0, FRAMES));
    q.push_back(mk(K_SPAWN, 1'b0, exp_score, 0));
    for (int i = 0; i < FRAMES; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
    step();
  endtask

  task automatic win_round();
    do_launch();
    collision = 1'b1;
    exp_score = (exp_score < 255) ? exp_score + 1 : 255;
    q.push_back(mk(K_ENTER, 1'b1, exp_score, 0));
    step();
    collision = 1'b0;
    finish_end();
  endtask

  initial begin
    repeat (3) step();
    check_reset_values();
    release_and_check_lfsr();

    // target_move lags its tick by one cycle in AIM
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("aim_target_move", 32'(target_move), 32'd1);
    check("aim_torpedo_move", 32'(torpedo_move), 32'd0);
    step();
    check("aim_move_drop", 32'(target_move), 32'd0);

    // launch, three frames of flight, then a hit
    do_launch();
    for (int f = 0; f < 3; f++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("flight_moves", 32'({target_move, torpedo_move}), 32'h3);
      step();
    end
    collision = 1'b1;
    exp_score = 1;
    q.push_back(mk(K_ENTER, 1'b1, 1, 0));
    step();
    collision = 1'b0;
    check("win_game_won", 32'(game_won), 32'd1);
    check("win_score", 32'(score), 32'd1);
    finish_end();
    check("won_cleared", 32'(game_won), 32'd0);

    // collision and torpedo_out together count as a win
    do_launch();
    collision = 1'b1;
    torpedo_out = 1'b1;
    exp_score = 2;
    q.push_back(mk(K_ENTER, 1'b1, 2, 0));
    step();
    collision = 1'b0;
    torpedo_out = 1'b0;
    finish_end();

    // target_out beats launch_req in AIM: loss, no launch
    target_out = 1'b1;
    launch_req = 1'b1;
    q.push_back(mk(K_ENTER, 1'b0, 2, 0));
    step();
    target_out = 1'b0;
    launch_req = 1'b0;
    check("aim_loss_no_launch", 32'(torpedo_launch), 32'd0);
    finish_end();

    // plain loss in flight, launch_req ignored there
    do_launch();
    launch_req = 1'b1;
    step();
    launch_req = 1'b0;
    torpedo_out = 1'b1;
    q.push_back(mk(K_ENTER, 1'b0, 2, 0));
    step();
    torpedo_out = 1'b0;
    finish_end();

    // score saturation
    for (int r = 0; r < 260; r++) win_round();
    check("score_saturated", 32'(score), 32'd255);

    // reset mid-flight
    do_launch();
    step();
    rst = 1'b1;
    #1;
    check_reset_values();
    check("queue_empty_at_reset", 32'(q.size()), 32'd0);
    step();
    exp_score = 0;
    release_and_check_lfsr();

    repeat (4) step();
    check("queue_empty_final", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
